mont_convert_stream: RTL and testbench

Streaming, pipelined converter that moves ML-KEM coefficients (Q = 3329) into or out of the Montgomery domain (R = 2^16), one coefficient per cycle, under valid/ready flow control. It performs the inverse direction of plain Montgomery reduction: to-Montgomery computes a·R mod Q, and from-Montgomery computes a·R^-1 mod Q. Output is canonical [0, Q). It sits between the sampler/decoder front end and the NTT/pointwise datapath, and again between that datapath and the encoder.

---
 rtl/poly_arith_pkg.sv | 27 ++
 rtl/mont_reduce_core.sv | 22 ++
 rtl/mont_convert_stream.sv | 99 +++++++++
 tb/tb_mont_convert_stream.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_arith_pkg.sv
// Shared ML-KEM coefficient arithmetic constants and types.
// Conversion constant selection lives here so every datapath agrees on K.
package poly_arith_pkg;

  localparam int unsigned PIPE_DEPTH = 3;

  localparam logic signed [15:0] Q        = 16'sd3329;
  localparam logic [15:0]        QINV_NEG = 16'd3327;
  localparam logic signed [15:0] R2_MOD_Q = 16'sd1353;

  typedef enum logic {
    MODE_TO_MONT   = 1'b0,
    MODE_FROM_MONT = 1'b1
  } conv_mode_e;

  // R^2 mod Q moves a value into the domain; 1 just strips one R factor.
  function automatic logic signed [15:0] mode_const(input conv_mode_e mode);
    logic signed [15:0] k;
    case (mode)
      MODE_TO_MONT:   k = R2_MOD_Q;
      MODE_FROM_MONT: k = 16'sd1;
      default:        k = 16'sd1;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/mont_reduce_core.sv
// Combinational signed Montgomery reduction: t = z * 2^-16 mod Q, t in (-Q, Q).
// Valid for |z| < Q * 2^15.
module mont_reduce_core
  import poly_arith_pkg::*;
(
  input  logic signed [31:0] z,
  output logic signed [15:0] t
);

  logic [15:0]        m_s;
  logic signed [31:0] mq_s;
  logic signed [31:0] sum_s;

  // QINV_NEG = -Q^-1 mod 2^16, so z + m*Q has sixteen zero low bits.
  always_comb begin
    m_s   = z[15:0] * QINV_NEG;
    mq_s  = 32'(signed'(m_s)) * 32'(Q);
    sum_s = z + mq_s;
    t     = 16'(sum_s >>> 16);
  end

endmodule

// File: rtl/mont_convert_stream.sv
// Three-stage streaming converter into / out of the Montgomery domain with
// valid/ready flow control and a per-polynomial output index counter.
module mont_convert_stream
  import poly_arith_pkg::*;
#(
  parameter int N_COEFF = 256
)
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic signed [15:0]           in_coeff_i,
  input  logic                         in_mode_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [15:0]                  out_coeff_o,
  output logic [$clog2(N_COEFF)-1:0]   out_idx_o,
  output logic                         out_last_o
);

  localparam int IDX_W = $clog2(N_COEFF);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_COEFF - 1);

  logic                    en_s;
  logic                    hs_s;
  logic signed [31:0]      z_s;
  logic signed [15:0]      red_s;
  logic signed [15:0]      canon_s;
  logic [IDX_W-1:0]        idx_nxt_s;

  logic                    s1_valid_r;
  logic signed [31:0]      s1_z_r;
  logic                    s2_valid_r;
  logic signed [15:0]      s2_t_r;
  logic                    s3_valid_r;
  logic [15:0]             s3_coeff_r;
  logic [IDX_W-1:0]        idx_r;
  logic                    last_r;

  // Stall control, S1 product, S3 canonicalisation and next index.
  always_comb begin
    en_s = !s3_valid_r || out_ready_i;
    hs_s = s3_valid_r && out_ready_i;
    z_s  = 32'(in_coeff_i) * 32'(mode_const(conv_mode_e'(in_mode_i)));
    if (s2_t_r < 16'sd0) begin
      canon_s = s2_t_r + Q;
    end else begin
      canon_s = s2_t_r;
    end
    if (idx_r == IDX_MAX) begin
      idx_nxt_s = '0;
    end else begin
      idx_nxt_s = idx_r + IDX_W'(1);
    end
  end

  mont_reduce_core u_reduce (
    .z (s1_z_r),
    .t (red_s)
  );

  // Pipeline stages; everything freezes together while the output is stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_r <= 1'b0;
      s1_z_r     <= 32'sd0;
      s2_valid_r <= 1'b0;
      s2_t_r     <= 16'sd0;
      s3_valid_r <= 1'b0;
      s3_coeff_r <= 16'd0;
    end else if (en_s) begin
      s1_valid_r <= in_valid_i;
      s1_z_r     <= z_s;
      s2_valid_r <= s1_valid_r;
      s2_t_r     <= red_s;
      s3_valid_r <= s2_valid_r;
      s3_coeff_r <= canon_s;
    end
  end

  // Index advances only on an output handshake; last is kept registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_r  <= '0;
      last_r <= 1'b0;
    end else if (hs_s) begin
      idx_r  <= idx_nxt_s;
      last_r <= (idx_nxt_s == IDX_MAX);
    end
  end

  assign in_ready_o  = en_s;
  assign out_valid_o = s3_valid_r;
  assign out_coeff_o = s3_coeff_r;
  assign out_idx_o   = idx_r;
  assign out_last_o  = last_r;

endmodule

// File: tb/tb_mont_convert_stream.sv
// Randomised self-checking bench for mont_convert_stream against an
// arithmetic reference (a*R mod Q, a*R^-1 mod Q).
module tb_mont_convert_stream;

  localparam int QM = 3329;
  localparam int NC = 256;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_coeff = 16'sd0;
  logic               in_mode = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [15:0]        out_coeff;
  logic [7:0]         out_idx;
  logic               out_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [15:0] in_a [4096];
  logic               in_m [4096];
  logic signed [15:0] orig_a [4096];
  logic [15:0]        out_c [4096];
  logic [7:0]         out_i [4096];
  logic               out_l [4096];
  int                 out_n;

  always #5 clk = ~clk;

  mont_convert_stream #(.N_COEFF(NC)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_coeff_i  (in_coeff),
    .in_mode_i   (in_mode),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_coeff_o (out_coeff),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last)
  );

  function automatic int ref_conv(input logic signed [15:0] a, input logic mode);
    longint x;
    longint r;
    x = mode ? longint'(a) * 169 : longint'(a) * 65536;
    r = x % QM;
    if (r < 0) r += QM;
    return int'(r);
  endfunction

  function automatic int canon_mod(input logic signed [15:0] a);
    int r;
    r = int'(a) % QM;
    if (r < 0) r += QM;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives in_a/in_m[0..n-1], collects handshaken outputs into out_*.
  task automatic run_stream(input int n, input int rdy_pct, input int vld_pct);
    int ptr;
    int budget;
    logic stalled;
    logic [15:0] pc;
    logic [7:0] pi;
    logic pl;
    ptr = 0;
    out_n = 0;
    budget = 0;
    stalled = 1'b0;
    pc = 16'd0;
    pi = 8'd0;
    pl = 1'b0;
    while (out_n < n && budget < n * 10 + 50) begin
      @(negedge clk);
      if (stalled) begin
        n_checks++;
        if (out_coeff !== pc || out_idx !== pi || out_last !== pl) begin
          n_fail++;
          $display("FAIL stable_while_stalled: got c=%0d i=%0d l=%0d need c=%0d i=%0d l=%0d",
                   out_coeff, out_idx, out_last, pc, pi, pl);
        end
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      if (ptr < n && $urandom_range(99) < vld_pct) begin
        in_valid = 1'b1;
        in_coeff = in_a[ptr];
        in_mode  = in_m[ptr];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++;
        $display("FAIL in_ready_rule: got %0b need %0b", in_ready, (!out_valid || out_ready));
      end
      if (in_valid && in_ready) ptr++;
      if (out_valid && out_ready) begin
        out_c[out_n] = out_coeff;
        out_i[out_n] = out_idx;
        out_l[out_n] = out_last;
        out_n++;
      end
      stalled = out_valid && !out_ready;
      pc = out_coeff;
      pi = out_idx;
      pl = out_last;
      budget++;
    end
    if (out_n < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL stream_timeout: got %0d outputs need %0d", out_n, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_coeff !== 16'd0 || out_idx !== 8'd0 ||
        out_last !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b c=%0d i=%0d l=%0b r=%0b need 0,0,0,0,1",
               out_valid, out_coeff, out_idx, out_last, in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    int cnt;
    do_reset();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_coeff = 16'sd1;
    in_mode = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (cnt !== 3) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles need 3", cnt);
    end
    n_checks++;
    if (out_coeff !== 16'd2285) begin
      n_fail++;
      $display("FAIL latency_value: got %0d need 2285", out_coeff);
    end
    @(negedge clk);
  endtask

  task automatic test_values();
    logic signed [15:0] va [8] = '{16'sd1, -16'sd1, 16'sd0, 16'sd2285, 16'sd1, 16'sd3328, -16'sd32768, 16'sd32767};
    logic               vm [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int                 ve [8] = '{2285, 1044, 0, 1, 169, 3160, 1664, 0};
    ve[7] = ref_conv(16'sd32767, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_a[i] = va[i];
      in_m[i] = vm[i];
    end
    run_stream(8, 100, 100);
    for (int i = 0; i < 8 && i < out_n; i++) begin
      n_checks++;
      if (int'(out_c[i]) !== ve[i] || out_i[i] !== 8'(i)) begin
        n_fail++;
        $display("FAIL known_value[%0d]: got c=%0d i=%0d need c=%0d i=%0d",
                 i, out_c[i], out_i[i], ve[i], i);
      end
    end
  endtask

  task automatic test_backpressure();
    int extra;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_a[i] = 16'($urandom);
      in_m[i] = 1'($urandom);
    end
    run_stream(8, 50, 80);
    for (int i = 0; i < 8 && i < out_n; i++) begin
      n_checks++;
      if (int'(out_c[i]) !== ref_conv(in_a[i], in_m[i])) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got %0d need %0d", i, out_c[i], ref_conv(in_a[i], in_m[i]));
      end
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL no_duplicate: got %0d extra valid cycles need 0", extra);
    end
  endtask

  task automatic test_index_wrap();
    do_reset();
    for (int i = 0; i < 2 * NC; i++) begin
      in_a[i] = 16'($urandom);
      in_m[i] = 1'($urandom);
    end
    run_stream(2 * NC, 100, 100);
    for (int i = 0; i < out_n; i++) begin
      n_checks++;
      if (int'(out_i[i]) !== (i % NC) || out_l[i] !== ((i % NC) == NC - 1)) begin
        n_fail++;
        $display("FAIL index_wrap[%0d]: got idx=%0d last=%0b need idx=%0d last=%0b",
                 i, out_i[i], out_l[i], i % NC, ((i % NC) == NC - 1));
      end
    end
  endtask

  task automatic test_round_trip();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      in_a[i] = 16'($urandom);
      in_m[i] = 1'(i % 2);
      if (i % 2 == 0) orig_a[i / 2] = in_a[i];
    end
    run_stream(2000, 80, 90);
    for (int i = 0; i < out_n; i++) begin
      n_checks++;
      if (int'(out_c[i]) !== ref_conv(in_a[i], in_m[i])) begin
        n_fail++;
        $display("FAIL mixed_mode[%0d]: got %0d need %0d", i, out_c[i], ref_conv(in_a[i], in_m[i]));
      end
    end
    for (int k = 0; k < 1000; k++) begin
      in_a[k] = signed'(out_c[2 * k]);
      in_m[k] = 1'b1;
    end
    run_stream(1000, 80, 90);
    for (int k = 0; k < out_n; k++) begin
      n_checks++;
      if (int'(out_c[k]) !== canon_mod(orig_a[k])) begin
        n_fail++;
        $display("FAIL round_trip[%0d]: got %0d need %0d", k, out_c[k], canon_mod(orig_a[k]));
      end
    end
  endtask

  task automatic test_reset_midstream();
    int stale;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_a[i] = 16'($urandom);
      in_m[i] = 1'b0;
    end
    run_stream(5, 100, 100);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_coeff = 16'($urandom);
      in_mode = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_idx !== 8'd5) begin
      n_fail++;
      $display("FAIL pre_reset_inflight: got v=%0b i=%0d need v=1 i=5", out_valid, out_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_idx !== 8'd0 || out_last !== 1'b0 || out_coeff !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_midstream: got v=%0b i=%0d l=%0b c=%0d need all 0",
               out_valid, out_idx, out_last, out_coeff);
    end
    out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    n_checks++;
    if (stale !== 0) begin
      n_fail++;
      $display("FAIL no_stale_after_reset: got %0d valid cycles need 0", stale);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout need completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_values();
    test_backpressure();
    test_index_wrap();
    test_round_trip();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
